// File: rtl/pin_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : pin_entry_controller
// Description : Keypad PIN sequencer: buffers 4 BCD digits, submits to checker,
//               reports unlock / fail / lockout verdict.
// Revision    : 1.0  initial release
// ============================================================================
module pin_entry_controller #(
  parameter int ENTRY_TIMEOUT = 1000,
  parameter int RESULT_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        chk_granted,
  input  logic        chk_denied,
  output logic [15:0] pin_out,
  output logic        pin_valid,
  output logic [2:0]  digit_count,
  output logic        busy,
  output logic        unlock,
  output logic        fail,
  output logic        locked,
  output logic        key_err,
  output logic        timeout
);

  localparam int IW = $clog2(ENTRY_TIMEOUT);
  localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [IW-1:0] C_IDLE_MAX = IW'(ENTRY_TIMEOUT - 1);
  localparam logic [LW-1:0] C_LAT_MAX  = LW'(RESULT_LAT - 1);

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_ENTRY   = 3'd1;
  localparam logic [2:0] C_ST_SUBMIT  = 3'd2;
  localparam logic [2:0] C_ST_WAIT    = 3'd3;
  localparam logic [2:0] C_ST_LOCKOUT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [LW-1:0] lat_q, lat_d;

  logic [15:0] pin_out_q, pin_out_d;
  logic        pin_valid_q, pin_valid_d;
  logic [2:0]  digit_count_q, digit_count_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        unlock_q, unlock_d;
  logic        fail_q, fail_d;
  logic        key_err_q, key_err_d;
  logic        timeout_q, timeout_d;

  logic w_is_digit;
  assign w_is_digit = (key_code <= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= C_ST_IDLE;
      buf_q         <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      lat_q         <= '0;
      pin_out_q     <= '0;
      pin_valid_q   <= 1'b0;
      digit_count_q <= '0;
      busy_q        <= 1'b0;
      locked_q      <= 1'b0;
      unlock_q      <= 1'b0;
      fail_q        <= 1'b0;
      key_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      lat_q         <= lat_d;
      pin_out_q     <= pin_out_d;
      pin_valid_q   <= pin_valid_d;
      digit_count_q <= digit_count_d;
      busy_q        <= busy_d;
      locked_q      <= locked_d;
      unlock_q      <= unlock_d;
      fail_q        <= fail_d;
      key_err_q     <= key_err_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    lat_d     = lat_q;
    unlock_d  = 1'b0;
    fail_d    = 1'b0;
    key_err_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      C_ST_IDLE, C_ST_ENTRY: begin
        if (state_q == C_ST_ENTRY) idle_d = idle_q + IW'(1);
        if (key_valid) begin
          idle_d = '0;
          if (w_is_digit) begin
            if (cnt_q == 3'd4) begin
              key_err_d = 1'b1;
            end else begin
              buf_d   = {buf_q[11:0], key_code};
              cnt_d   = cnt_q + 3'd1;
              state_d = C_ST_ENTRY;
            end
          end else begin
            case (key_code)
              4'hA: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = C_ST_IDLE;
              end
              4'hB: begin
                if (cnt_q != 3'd0) begin
                  buf_d = buf_q >> 4;
                  cnt_d = cnt_q - 3'd1;
                  if (cnt_q == 3'd1) state_d = C_ST_IDLE;
                end
              end
              4'hE: begin
                if (cnt_q == 3'd4) begin
                  state_d = C_ST_SUBMIT;
                end else begin
                  key_err_d = 1'b1;
                  buf_d     = '0;
                  cnt_d     = '0;
                  state_d   = C_ST_IDLE;
                end
              end
              default: key_err_d = 1'b1;
            endcase
          end
        end else if (state_q == C_ST_ENTRY && idle_q == C_IDLE_MAX) begin
          buf_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = C_ST_IDLE;
        end
        if (state_d != C_ST_ENTRY) idle_d = '0;
      end
      C_ST_SUBMIT: begin
        key_err_d = key_valid;
        lat_d     = '0;
        state_d   = C_ST_WAIT;
      end
      C_ST_WAIT: begin
        key_err_d = key_valid;
        if (lat_q == C_LAT_MAX) begin
          // Deny outranks grant: a locked-out checker may still echo granted.
          if (chk_denied) begin
            state_d = C_ST_LOCKOUT;
          end else if (chk_granted) begin
            unlock_d = 1'b1;
            state_d  = C_ST_IDLE;
          end else begin
            fail_d  = 1'b1;
            state_d = C_ST_IDLE;
          end
          buf_d = '0;
          cnt_d = '0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      C_ST_LOCKOUT: begin
        key_err_d = key_valid;
        if (!chk_denied) state_d = C_ST_IDLE;
      end
      default: begin
        state_d = C_ST_IDLE;
        buf_d   = '0;
        cnt_d   = '0;
        idle_d  = '0;
      end
    endcase
  end

  always_comb begin
    pin_out_d     = (state_d == C_ST_SUBMIT || state_d == C_ST_WAIT) ? buf_d : 16'h0000;
    pin_valid_d   = (state_d == C_ST_SUBMIT);
    digit_count_d = (state_d == C_ST_IDLE || state_d == C_ST_ENTRY) ? cnt_d : 3'd0;
    busy_d        = (state_d == C_ST_SUBMIT) || (state_d == C_ST_WAIT) ||
                    (state_d == C_ST_LOCKOUT);
    locked_d      = (state_d == C_ST_LOCKOUT);
  end

  assign pin_out     = pin_out_q;
  assign pin_valid   = pin_valid_q;
  assign digit_count = digit_count_q;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign unlock      = unlock_q;
  assign fail        = fail_q;
  assign key_err     = key_err_q;
  assign timeout     = timeout_q;

endmodule
`default_nettype wire
